bcd_converter_seq: RTL and testbench

//  Parametrised, multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_converter_seq_if.sv | 26 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bcd_converter_seq.sv | 126 ++++++++++++
 tb/tb_bcd_converter_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of a down-counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Valid/ready bus between a producer/consumer (master) and the converter (slave).
interface bcd_converter_seq_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                          in_valid;
    logic                          in_ready;
    logic [BIN_W-1:0]              bin_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic                          sign_out;
    logic                          overflow;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, sign_out, overflow
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, sign_out, overflow
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble step: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);
    // Conditional +3 adjust.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end
    end
endmodule

// File: rtl/bcd_converter_seq.sv
// Multi-cycle binary-to-BCD converter, one shift-and-add-3 step per clock.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | ready for a new value; in_ready=1
//   ST_SHIFT | BIN_W adjust+shift steps, counter counts down to 1
//   ST_DONE  | result presented on out_valid, held until out_ready
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W     = 8,
    parameter int DIGITS    = 3,
    parameter int SIGNED_EN = 0
) (
    input logic               clk,
    input logic               rst_n,
    bcd_converter_seq_if.slave bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;
    logic               ovf_q;
    logic [BIN_W-1:0]   mag;
    logic               neg;
    logic               accept;
    logic               last_step;
    logic [BCD_W-1:0]   bcd_shifted;
    logic               ovf_step;

    logic [BCD_W-1:0]   bcd_o;
    logic               sign_o;
    logic               ovf_o;
    logic               valid_o;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_q  [d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Magnitude and sign of the incoming value; -2**(BIN_W-1) negates onto itself,
    // which read as unsigned is exactly the right magnitude.
    always_comb begin
        mag = bus.bin_in;
        neg = 1'b0;
        if (SIGNED_EN != 0 && bus.bin_in[BIN_W-1]) begin
            neg = 1'b1;
            mag = -bus.bin_in;
        end
    end

    assign accept      = (state == ST_IDLE) && bus.in_valid;
    assign last_step   = (state == ST_SHIFT) && (cnt_q == CNT_W'(1));
    assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign ovf_step    = ovf_q | bcd_adj[BCD_W-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.in_valid)  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_step)     state_nxt = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Working shift registers and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            bin_q  <= mag;
            bcd_q  <= '0;
            cnt_q  <= CNT_W'(BIN_W);
            sign_q <= neg;
            ovf_q  <= 1'b0;
        end else if (state == ST_SHIFT) begin
            bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
            bcd_q  <= bcd_shifted;
            cnt_q  <= cnt_q - CNT_W'(1);
            ovf_q  <= ovf_step;
        end
    end

    // Result registers, loaded only on the final step so no partial value is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_o   <= '0;
            sign_o  <= 1'b0;
            ovf_o   <= 1'b0;
            valid_o <= 1'b0;
        end else if (last_step) begin
            bcd_o   <= bcd_shifted;
            sign_o  <= sign_q;
            ovf_o   <= ovf_step;
            valid_o <= 1'b1;
        end else if (valid_o && bus.out_ready) begin
            valid_o <= 1'b0;
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = valid_o;
    assign bus.bcd_out   = bcd_o;
    assign bus.sign_out  = sign_o;
    assign bus.overflow  = ovf_o;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: several parameter sets side by side, directed cases
// plus a random sweep against a divide-by-10 reference model.
module tb_bcd_converter_seq;
    localparam int NCFG = 6;

    function automatic int cfg_bw(input int k);
        case (k)
            3:       return 4;
            4:       return 12;
            5:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_dg(input int k);
        case (k)
            1:       return 2;
            3:       return 2;
            4:       return 4;
            5:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_sg(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rst_n;
    logic        iv   [NCFG];
    logic [15:0] bi   [NCFG];
    logic        ordy [NCFG];
    logic        ir   [NCFG];
    logic        ov   [NCFG];
    logic        so   [NCFG];
    logic        of   [NCFG];
    logic [19:0] bo   [NCFG];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int BW = cfg_bw(g);
        localparam int DG = cfg_dg(g);
        localparam int SG = cfg_sg(g);

        bcd_converter_seq_if #(.BIN_W(BW), .DIGITS(DG)) bus ();

        assign bus.in_valid  = iv[g];
        assign bus.bin_in    = bi[g][BW-1:0];
        assign bus.out_ready = ordy[g];
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign so[g] = bus.sign_out;
        assign of[g] = bus.overflow;
        assign bo[g] = 20'(bus.bcd_out);

        bcd_converter_seq #(.BIN_W(BW), .DIGITS(DG), .SIGNED_EN(SG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference: sign/magnitude from the raw bits, then decimal digits by repeated /10.
    function automatic void ref_model(input int bw, input int dg, input int sg, input longint v,
                                      output longint bcd, output bit sgn, output bit ovf);
        longint raw, mag, lim, r;
        raw = v & ((64'sd1 << bw) - 1);
        sgn = 1'b0;
        mag = raw;
        if (sg != 0 && raw >= (64'sd1 << (bw - 1))) begin
            sgn = 1'b1;
            mag = (64'sd1 << bw) - raw;
        end
        lim = 1;
        for (int i = 0; i < dg; i++) lim = lim * 10;
        ovf = (mag >= lim);
        r   = mag % lim;
        bcd = 0;
        for (int i = 0; i < dg; i++) begin
            bcd = bcd | ((r % 10) << (4 * i));
            r   = r / 10;
        end
    endfunction

    // Convert one value on config k; leaves the result pending unless release_out is set.
    task automatic do_conv(input int k, input longint v, input bit release_out,
                           output longint eb, output bit es, output bit eo);
        int lat;
        int bw;
        bw = cfg_bw(k);
        ref_model(bw, cfg_dg(k), cfg_sg(k), v, eb, es, eo);
        chk($sformatf("c%0d ready_before v=%0h", k, v), ir[k], 1);
        iv[k] = 1'b1;
        bi[k] = 16'(v);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        bi[k] = 16'($urandom);
        lat = 0;
        while (ov[k] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("c%0d latency v=%0h", k, v), 64'(lat), 64'(bw));
        chk($sformatf("c%0d bcd v=%0h", k, v), bo[k], eb);
        chk($sformatf("c%0d sign v=%0h", k, v), so[k], es);
        chk($sformatf("c%0d ovf v=%0h", k, v), of[k], eo);
        chk($sformatf("c%0d ready_busy v=%0h", k, v), ir[k], 0);
        if (release_out) begin
            ordy[k] = 1'b1;
            @(posedge clk);
            #1;
            ordy[k] = 1'b0;
            chk($sformatf("c%0d valid_drop v=%0h", k, v), ov[k], 0);
            chk($sformatf("c%0d ready_back v=%0h", k, v), ir[k], 1);
        end
    endtask

    initial begin
        longint eb;
        bit     es, eo;
        int     bw;

        rst_n = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            iv[k] = 1'b0; bi[k] = '0; ordy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            chk($sformatf("c%0d rst in_ready", k), ir[k], 1);
            chk($sformatf("c%0d rst out_valid", k), ov[k], 0);
            chk($sformatf("c%0d rst bcd", k), bo[k], 0);
            chk($sformatf("c%0d rst sign", k), so[k], 0);
            chk($sformatf("c%0d rst ovf", k), of[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-scale, digit boundaries, overflow and signed corners.
        do_conv(0, 255, 1, eb, es, eo);
        chk("t1 bcd_255_const", bo[0], 20'h255);
        do_conv(0, 0,   1, eb, es, eo);
        do_conv(0, 9,   1, eb, es, eo);
        do_conv(0, 10,  1, eb, es, eo);
        chk("t2 bcd_10_const", bo[0], 20'h010);
        do_conv(1, 200, 1, eb, es, eo);
        chk("t3 ovf_200_const", of[1], 1);
        do_conv(1, 99,  1, eb, es, eo);
        chk("t3 bcd_99_const", bo[1], 20'h99);
        do_conv(2, 8'h80, 1, eb, es, eo);
        chk("t4 bcd_m128_const", bo[2], 20'h128);
        do_conv(2, 8'hFF, 1, eb, es, eo);
        do_conv(2, 127,   1, eb, es, eo);

        // Back-pressure: result must hold while in_valid is ignored.
        do_conv(0, 173, 0, eb, es, eo);
        iv[0] = 1'b1;
        bi[0] = 16'd77;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t5 hold valid %0d", i), ov[0], 1);
            chk($sformatf("t5 hold bcd %0d", i), bo[0], eb);
            chk($sformatf("t5 hold ready %0d", i), ir[0], 0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        chk("t5 release valid", ov[0], 0);
        chk("t5 release ready", ir[0], 1);
        do_conv(0, 42, 1, eb, es, eo);

        // Reset three cycles into a conversion.
        iv[0] = 1'b1;
        bi[0] = 16'd200;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 rst in_ready", ir[0], 1);
        chk("t6 rst out_valid", ov[0], 0);
        chk("t6 rst bcd", bo[0], 0);
        chk("t6 rst ovf", of[0], 0);
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("t6 no_result_in_rst", ov[0], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 post_rst out_valid", ov[0], 0);
        do_conv(0, 37, 1, eb, es, eo);
        chk("t6 bcd_37_const", bo[0], 20'h037);

        // Random sweep over every configuration.
        for (int k = 0; k < NCFG; k++) begin
            bw = cfg_bw(k);
            for (int n = 0; n < 20; n++) begin
                do_conv(k, longint'($urandom) & ((64'sd1 << bw) - 1), 1, eb, es, eo);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
